// File: rtl/spm_pkg.sv
// spm_pkg: shared FSM states, default sizes and requester id type for the SPM arbiter
package spm_pkg;
   localparam int W_DEF = 8;
   localparam int TIMEOUT_DEF = 32;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DELIVER} state_t;
   typedef logic id_t;
endpackage

// File: rtl/spm_arbiter_if.sv
// spm_arbiter_if: requester handshake and multiplier signals bundled for the SPM arbiter
interface spm_arbiter_if #(parameter int W = spm_pkg::W_DEF);
   logic [1:0] req, ack, rsp_valid, rsp_ready;
   logic [W-1:0] op_x0, op_y0, op_x1, op_y1, spm_x, spm_y;
   logic [2*W-1:0] rsp_data, spm_p;
   logic rsp_err, spm_go, spm_done, busy;
   modport master (
      output req, op_x0, op_y0, op_x1, op_y1, rsp_ready, spm_done, spm_p,
      input ack, rsp_valid, rsp_data, rsp_err, spm_go, spm_x, spm_y, busy
   );
   modport slave (
      input req, op_x0, op_y0, op_x1, op_y1, rsp_ready, spm_done, spm_p,
      output ack, rsp_valid, rsp_data, rsp_err, spm_go, spm_x, spm_y, busy
   );
endinterface

// File: rtl/spm_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin choice; on a tie the requester not granted last wins
module rr_pick2
   import spm_pkg::*;
(
   input  logic [1:0] req,
   input  id_t        last,
   output logic       grant_valid,
   output id_t        grant_id
);
   // a lone request wins outright; a double request goes to the other side of last
   always_comb begin
      grant_valid = |req;
      grant_id = (req == 2'b11) ? ~last : req[1];
   end
endmodule

// File: rtl/spm_arbiter.sv
// spm_arbiter: shares one serial-parallel multiplier between two requesters with timeout
module spm_arbiter
   import spm_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic clk,
   input logic R,
   spm_arbiter_if.slave bus
);
   state_t state, next;
   id_t id, last, grant_id;
   logic grant_valid, tmo;
   logic [W-1:0] x, y;
   logic [2*W-1:0] data;
   logic err;
   logic [7:0] cnt;

   rr_pick2 u_pick (.req(bus.req), .last(last), .grant_valid(grant_valid), .grant_id(grant_id));

   assign tmo = cnt == 8'(TIMEOUT - 1);

   // state register
   always_ff @(posedge clk or posedge R)
      if (R) state <= IDLE;
      else state <= next;

   // next-state: done beats timeout in WAIT; DELIVER only leaves on the owner's ready
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = grant_valid ? LAUNCH : IDLE;
         LAUNCH:  next = WAIT;
         WAIT:    next = (bus.spm_done || tmo) ? DELIVER : WAIT;
         DELIVER: next = bus.rsp_ready[id] ? IDLE : DELIVER;
         default: next = IDLE;
      endcase
   end

   // datapath: operand capture, wait counter, result latch and round-robin history
   always_ff @(posedge clk or posedge R)
      if (R) begin
         id <= 1'b0;
         last <= 1'b1;
         x <= '0;
         y <= '0;
         data <= '0;
         err <= 1'b0;
         cnt <= '0;
      end else begin
         if (state == IDLE && grant_valid) begin
            id <= grant_id;
            x <= grant_id ? bus.op_x1 : bus.op_x0;
            y <= grant_id ? bus.op_y1 : bus.op_y0;
         end
         cnt <= (state == WAIT) ? cnt + 8'd1 : 8'd0;
         if (state == WAIT && bus.spm_done) begin
            data <= bus.spm_p;
            err <= 1'b0;
         end else if (state == WAIT && tmo) begin
            data <= '0;
            err <= 1'b1;
         end
         if (state == DELIVER && bus.rsp_ready[id]) last <= id;
      end

   // outputs decoded from state and the captured requester id
   always_comb begin
      bus.ack = (state == LAUNCH) ? (id ? 2'b10 : 2'b01) : 2'b00;
      bus.rsp_valid = (state == DELIVER) ? (id ? 2'b10 : 2'b01) : 2'b00;
      bus.spm_go = state == LAUNCH;
      bus.busy = state != IDLE;
      bus.spm_x = x;
      bus.spm_y = y;
      bus.rsp_data = data;
      bus.rsp_err = err;
   end
endmodule

// File: tb/tb_spm_arbiter.sv
// tb_spm_arbiter: randomized rounds against a transaction-level model of the arbiter
module tb_spm_arbiter;
   import spm_pkg::*;
   localparam int W = 8;
   localparam int TO = 32;

   logic clk = 1'b0;
   logic R = 1'b1;
   int n_chk = 0;
   int n_pass = 0;
   logic [1:0] pend = 2'b00;
   int last = 1;
   logic signed [W-1:0] opx [2];
   logic signed [W-1:0] opy [2];

   spm_arbiter_if #(.W(W)) bus ();
   spm_arbiter #(.W(W), .TIMEOUT(TO)) dut (.clk(clk), .R(R), .bus(bus));

   always #5 clk = ~clk;

   assign bus.op_x0 = opx[0];
   assign bus.op_y0 = opy[0];
   assign bus.op_x1 = opx[1];
   assign bus.op_y1 = opy[1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic prep(input logic [1:0] add);
      for (int i = 0; i < 2; i++)
         if (add[i] && !pend[i]) begin
            opx[i] = W'($urandom);
            opy[i] = W'($urandom);
         end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ack"}, bus.ack, 0);
      chk({tag, "_valid"}, bus.rsp_valid, 0);
      chk({tag, "_data"}, bus.rsp_data, 0);
      chk({tag, "_err"}, bus.rsp_err, 0);
      chk({tag, "_go"}, bus.spm_go, 0);
      chk({tag, "_x"}, bus.spm_x, 0);
      chk({tag, "_y"}, bus.spm_y, 0);
      chk({tag, "_busy"}, bus.busy, 0);
   endtask

   // one full transaction from an IDLE negedge; d = WAIT cycle index of spm_done, rdel = ready delay
   task automatic round(input logic [1:0] add, input int d, input int rdel);
      logic [1:0] r;
      int w;
      logic e;
      logic signed [2*W-1:0] p;
      r = pend | add;
      w = (r == 2'b11) ? 1 - last : (r[1] ? 1 : 0);
      e = d > TO - 1;
      if (e) p = '0;
      else p = opx[w] * opy[w];
      bus.req = r;
      @(negedge clk);
      chk("ack", bus.ack, 2'b1 << w);
      chk("go", bus.spm_go, 1);
      chk("spm_x", bus.spm_x, $unsigned(opx[w]));
      chk("spm_y", bus.spm_y, $unsigned(opy[w]));
      chk("busy", bus.busy, 1);
      r[w] = 1'b0;
      bus.req = r;
      pend = r;
      @(negedge clk);
      for (int k = 0; k <= (e ? TO - 1 : d); k++) begin
         chk("wait_valid", bus.rsp_valid, 0);
         chk("wait_ack", bus.ack, 0);
         chk("wait_go", bus.spm_go, 0);
         chk("wait_x", bus.spm_x, $unsigned(opx[w]));
         chk("wait_y", bus.spm_y, $unsigned(opy[w]));
         bus.spm_done = k == d;
         bus.spm_p = (k == d) ? $unsigned(p) : 2*W'($urandom);
         @(negedge clk);
      end
      bus.spm_done = 1'b0;
      for (int c = 0; c <= rdel; c++) begin
         chk("dv_valid", bus.rsp_valid, 2'b1 << w);
         chk("dv_data", bus.rsp_data, $unsigned(p));
         chk("dv_err", bus.rsp_err, e);
         chk("dv_ack", bus.ack, 0);
         chk("dv_go", bus.spm_go, 0);
         bus.rsp_ready = (c == rdel) ? (2'b1 << w) : ((2'b1 << (1 - w)) & 2'($urandom));
         bus.spm_done = (c < rdel) ? 1'($urandom) : 1'b0;
         bus.spm_p = 2*W'($urandom);
         @(negedge clk);
      end
      bus.rsp_ready = 2'b00;
      bus.spm_done = 1'b0;
      chk("idle_busy", bus.busy, 0);
      chk("idle_valid", bus.rsp_valid, 0);
      last = w;
   endtask

   // reset pulse while the multiplier is still working, followed by a stale done
   task automatic reset_mid();
      pend = 2'b00;
      prep(2'b01);
      bus.req = 2'b01;
      @(negedge clk);
      bus.req = 2'b00;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", bus.busy, 1);
      #2 R = 1'b1;
      #1 chk_zero("rst_mid");
      #1 R = 1'b0;
      @(negedge clk);
      bus.spm_done = 1'b1;
      bus.spm_p = 2*W'($urandom);
      @(negedge clk);
      bus.spm_done = 1'b0;
      repeat (3) begin
         chk("post_rst_busy", bus.busy, 0);
         chk("post_rst_valid", bus.rsp_valid, 0);
         chk("post_rst_ack", bus.ack, 0);
         @(negedge clk);
      end
      last = 1;
   endtask

   initial begin
      logic [1:0] add;
      bus.req = 2'b00;
      bus.rsp_ready = 2'b00;
      bus.spm_done = 1'b0;
      bus.spm_p = '0;
      opx[0] = '0; opy[0] = '0; opx[1] = '0; opy[1] = '0;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      R = 1'b0;
      @(negedge clk);
      opx[0] = 8'sd5;
      opy[0] = -8'sd3;
      round(2'b01, 15, 0);
      chk("mul_5x-3", bus.rsp_data, 16'hFFF1);
      prep(2'b11); round(2'b11, 4, 1);
      round(2'b00, 6, 0);
      prep(2'b11); round(2'b11, 2, 0);
      round(2'b00, 9, 2);
      prep(2'b01); round(2'b01, 1000, 2);
      prep(2'b10); round(2'b10, TO - 1, 0);
      prep(2'b11); round(2'b11, 3, 5);
      round(2'b00, 0, 0);
      reset_mid();
      prep(2'b11); round(2'b11, 5, 0);
      round(2'b00, 5, 0);
      for (int i = 0; i < 40; i++) begin
         add = 2'($urandom_range(0, 3));
         if ((pend | add) == 2'b00) add = 2'b01;
         prep(add);
         round(add, $urandom_range(0, 40), $urandom_range(0, 4));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
